// File: rtl/mult_rr_arbiter.sv
// mult_rr_arbiter
//   Shares one pipelined 16x16 signed Q1.15 multiplier among NREQ requesters.
//   Each cycle a round-robin arbiter grants at most one requester. The granted
//   operands are registered onto mul_a/mul_b. A {valid, id} tag travels
//   alongside the multiplier pipeline, so each Q1.31 product returns on
//   res_valid/res_id/res_data MUL_LAT+2 cycles after its grant.
//
// Ports
//   clk, reset  : clock and synchronous active-high reset (also resets the multiplier)
//   req         : per-requester request, held until granted
//   a_in, b_in  : packed operands, requester i uses [16i+15:16i]
//   gnt         : one-hot combinational grant (zero while reset is high)
//   mul_a/mul_b : registered operands to the shared multiplier
//   mul_y       : multiplier product, Q1.31
//   res_valid   : registered result strobe
//   res_id      : registered owner index of res_data
//   res_data    : registered product
//   inflight    : registered count of issued, not yet returned, operations
//   busy        : work pending (inflight != 0 or any request)
module mult_rr_arbiter #(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 5,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   a_in,
  input  logic [16*NREQ-1:0]   b_in,
  output logic [NREQ-1:0]      gnt,
  output logic [15:0]          mul_a,
  output logic [15:0]          mul_b,
  input  logic [31:0]          mul_y,
  output logic                 res_valid,
  output logic [IDW-1:0]       res_id,
  output logic [31:0]          res_data,
  output logic [3:0]           inflight,
  output logic                 busy
);

  logic [IDW-1:0] rr_ptr;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic [15:0]    a_arr [NREQ];
  logic [15:0]    b_arr [NREQ];
  logic [MUL_LAT:0] tag_valid;
  logic [IDW-1:0]   tag_id [MUL_LAT+1];

  // Unpack the flat operand buses so the granted slice is a simple array read.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = a_in[16*g +: 16];
    assign b_arr[g] = b_in[16*g +: 16];
  end

  // Round-robin search: first active request starting just after rr_ptr.
  always_comb begin
    logic [IDW-1:0] idx;
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_id    = idx;
      end else begin
        grant_valid = grant_valid;
      end
    end
    // A grant during reset would be lost, so none is offered.
    if (reset) begin
      grant_valid = 1'b0;
    end else begin
      grant_valid = grant_valid;
    end
  end

  // Expand the granted index into the one-hot grant vector.
  always_comb begin
    gnt = '0;
    if (grant_valid) begin
      gnt[grant_id] = 1'b1;
    end else begin
      gnt = '0;
    end
  end

  // Pointer, operand issue, tag pipeline, result capture and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= IDW'(NREQ - 1);
      mul_a     <= 16'h0000;
      mul_b     <= 16'h0000;
      tag_valid <= '0;
      for (int i = 0; i <= MUL_LAT; i++) begin
        tag_id[i] <= '0;
      end
      res_valid <= 1'b0;
      res_id    <= '0;
      res_data  <= 32'h0000_0000;
      inflight  <= 4'd0;
    end else begin
      if (grant_valid) begin
        rr_ptr <= grant_id;
        mul_a  <= a_arr[grant_id];
        mul_b  <= b_arr[grant_id];
      end else begin
        mul_a  <= 16'h0000;
        mul_b  <= 16'h0000;
      end
      // Stage MUL_LAT lines up with mul_y; res_* is registered one edge later.
      tag_valid <= {tag_valid[MUL_LAT-1:0], grant_valid};
      tag_id[0] <= grant_id;
      for (int i = 1; i <= MUL_LAT; i++) begin
        tag_id[i] <= tag_id[i-1];
      end
      res_valid <= tag_valid[MUL_LAT];
      res_id    <= tag_id[MUL_LAT];
      res_data  <= mul_y;
      // An op counts from its issue edge until the end of its res_valid cycle.
      case ({grant_valid, res_valid})
        2'b10:   inflight <= inflight + 4'd1;
        2'b01:   inflight <= inflight - 4'd1;
        default: inflight <= inflight;
      endcase
    end
  end

  assign busy = (inflight != 4'd0) || (|req);

endmodule

// File: tb/tb_mult_rr_arbiter.sv
module tb_mult_rr_arbiter;

  localparam int NREQ    = 4;
  localparam int MUL_LAT = 5;
  localparam int IDW     = 2;

  logic                clk;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [16*NREQ-1:0]  a_in;
  logic [16*NREQ-1:0]  b_in;
  logic [NREQ-1:0]     gnt;
  logic [15:0]         mul_a;
  logic [15:0]         mul_b;
  logic [31:0]         mul_y;
  logic                res_valid;
  logic [IDW-1:0]      res_id;
  logic [31:0]         res_data;
  logic [3:0]          inflight;
  logic                busy;

  mult_rr_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt),
    .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y), .res_valid(res_valid),
    .res_id(res_id), .res_data(res_data), .inflight(inflight), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Q1.15 x Q1.15 -> Q1.31
  function automatic logic [31:0] q15mul(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p <<< 1;
  endfunction

  // Shared multiplier: MUL_LAT register stages from mul_a/mul_b to mul_y.
  logic [31:0] mpipe [MUL_LAT];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MUL_LAT; i++) mpipe[i] <= 32'h0;
    end else begin
      mpipe[0] <= q15mul(mul_a, mul_b);
      for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign mul_y = mpipe[MUL_LAT-1];

  // Reference model state
  typedef struct {
    int          issued;
    int          due;
    int          id;
    logic [31:0] prod;
  } op_t;
  op_t         q[$];
  int          ptr;
  int          cyc;
  logic [15:0] exp_ma, exp_mb;

  int n_assert = 0;
  int n_fail   = 0;

  logic [NREQ-1:0] obs_gnt;
  logic            obs_rv;
  logic [IDW-1:0]  obs_rid;
  logic [31:0]     obs_rd;
  logic [3:0]      obs_infl;
  logic [15:0]     obs_ma;
  logic            obs_busy;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive, sample at negedge, compare to model, advance model.
  task automatic step(input logic rst, input logic [NREQ-1:0] r,
                      input logic [16*NREQ-1:0] a, input logic [16*NREQ-1:0] b);
    logic [NREQ-1:0] eg;
    int gid;
    int infl;
    logic erv;
    reset = rst; req = r; a_in = a; b_in = b;
    @(negedge clk);
    eg  = '0;
    gid = -1;
    if (!rst) begin
      for (int k = 1; k <= NREQ; k++) begin
        int idx;
        idx = (ptr + k) % NREQ;
        if (gid < 0 && r[idx]) gid = idx;
      end
    end
    if (gid >= 0) eg[gid] = 1'b1;
    while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
    infl = 0;
    foreach (q[i]) if (q[i].issued < cyc && q[i].due >= cyc) infl++;
    erv = (q.size() > 0) && (q[0].due == cyc);

    check("gnt", 32'(gnt), 32'(eg));
    check("res_valid", 32'(res_valid), 32'(erv));
    if (erv) begin
      check("res_id", 32'(res_id), 32'(q[0].id));
      check("res_data", res_data, q[0].prod);
    end
    check("inflight", 32'(inflight), 32'(infl));
    check("busy", 32'(busy), 32'((infl != 0) || (|r)));
    check("mul_a", 32'(mul_a), 32'(exp_ma));
    check("mul_b", 32'(mul_b), 32'(exp_mb));

    obs_gnt = gnt; obs_rv = res_valid; obs_rid = res_id; obs_rd = res_data;
    obs_infl = inflight; obs_ma = mul_a; obs_busy = busy;

    if (rst) begin
      q.delete();
      ptr = NREQ - 1;
      exp_ma = 16'h0; exp_mb = 16'h0;
    end else if (gid >= 0) begin
      q.push_back('{issued: cyc, due: cyc + MUL_LAT + 2, id: gid,
                    prod: q15mul(a[16*gid +: 16], b[16*gid +: 16])});
      ptr = gid;
      exp_ma = a[16*gid +: 16];
      exp_mb = b[16*gid +: 16];
    end else begin
      exp_ma = 16'h0; exp_mb = 16'h0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16*NREQ-1:0] rnd_ops();
    logic [16*NREQ-1:0] v;
    for (int i = 0; i < NREQ; i++) v[16*i +: 16] = 16'($urandom);
    return v;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'b0000, 64'h0, 64'h0);
  endtask

  initial begin
    int rv_count;
    int max_infl;
    reset = 1'b1; req = '0; a_in = '0; b_in = '0;
    cyc = 0; ptr = NREQ - 1; exp_ma = 16'h0; exp_mb = 16'h0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    step(1'b1, 4'b0001, 64'h0, 64'h0);
    check("reset_gnt", 32'(obs_gnt), 32'h0);
    check("reset_res_valid", 32'(obs_rv), 32'h0);
    check("reset_res_data", obs_rd, 32'h0);
    check("reset_inflight", 32'(obs_infl), 32'h0);

    // Single op: 0.5 * 0.5
    step(1'b0, 4'b0001, 64'h0000_0000_0000_4000, 64'h0000_0000_0000_4000);
    check("single_gnt", 32'(obs_gnt), 32'h1);
    step(1'b0, 4'b0000, 64'h0, 64'h0);
    check("single_inflight1", 32'(obs_infl), 32'd1);
    idle(5);
    step(1'b0, 4'b0000, 64'h0, 64'h0);
    check("single_rv", 32'(obs_rv), 32'h1);
    check("single_rid", 32'(obs_rid), 32'h0);
    check("single_rd", obs_rd, 32'h2000_0000);
    step(1'b0, 4'b0000, 64'h0, 64'h0);
    check("single_inflight0", 32'(obs_infl), 32'd0);

    // Sign handling: -0.5 * 0.5 on requester 2
    step(1'b0, 4'b0100, 64'h0000_C000_0000_0000, 64'h0000_4000_0000_0000);
    check("sign_gnt", 32'(obs_gnt), 32'h4);
    idle(6);
    step(1'b0, 4'b0000, 64'h0, 64'h0);
    check("sign_rid", 32'(obs_rid), 32'h2);
    check("sign_rd", obs_rd, 32'hE000_0000);

    // Round robin from a fresh pointer
    step(1'b1, 4'b0000, 64'h0, 64'h0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 4'b1111, rnd_ops(), rnd_ops());
      check("rr_gnt", 32'(obs_gnt), 32'(1 << (i % NREQ)));
    end
    idle(10);

    // Skip and wrap: put pointer at 1, then req=1001
    step(1'b0, 4'b0010, rnd_ops(), rnd_ops());
    step(1'b0, 4'b1001, rnd_ops(), rnd_ops());
    check("wrap_gnt3", 32'(obs_gnt), 32'h8);
    step(1'b0, 4'b1001, rnd_ops(), rnd_ops());
    check("wrap_gnt0", 32'(obs_gnt), 32'h1);
    step(1'b0, 4'b0010, rnd_ops(), rnd_ops());
    check("wrap_gnt1", 32'(obs_gnt), 32'h2);
    idle(10);

    // Reset mid-flight: 3 issues then reset in T+3
    step(1'b0, 4'b0001, rnd_ops(), rnd_ops());
    step(1'b0, 4'b0010, rnd_ops(), rnd_ops());
    step(1'b0, 4'b0100, rnd_ops(), rnd_ops());
    step(1'b1, 4'b1111, rnd_ops(), rnd_ops());
    check("rst_gnt", 32'(obs_gnt), 32'h0);
    step(1'b0, 4'b0000, 64'h0, 64'h0);
    check("rst_inflight", 32'(obs_infl), 32'h0);
    check("rst_mul_a", 32'(obs_ma), 32'h0);
    idle(2);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b0000, 64'h0, 64'h0);
      check("rst_no_rv", 32'(obs_rv), 32'h0);
    end
    step(1'b0, 4'b0110, rnd_ops(), rnd_ops());
    check("rst_first_gnt", 32'(obs_gnt), 32'h2);
    idle(10);

    // Idle
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 4'b0000, 64'h0, 64'h0);
      check("idle_rv", 32'(obs_rv), 32'h0);
      check("idle_busy", 32'(obs_busy), 32'h0);
      check("idle_mul_a", 32'(obs_ma), 32'h0);
    end

    // Streaming from one requester
    rv_count = 0;
    max_infl = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, (i < 10) ? 4'b0100 : 4'b0000, rnd_ops(), rnd_ops());
      if (obs_rv) rv_count++;
      if (int'(obs_infl) > max_infl) max_infl = int'(obs_infl);
    end
    check("stream_rv_count", 32'(rv_count), 32'd10);
    check("stream_inflight_le7", 32'(max_infl <= 7), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 4'($urandom), rnd_ops(), rnd_ops());
    end
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
